mcu_bus_decoder: RTL and testbench
==================================

MCU_BUS_DECODER -- requirements
Module: mcu_bus_decoder

Interface
REQ-001 SHALL have parameters: H_RES 800, panel columns; V_RES 480, panel rows; FIFO_DEPTH 4, pixel FIFO entries (power of 2, ≥2).
REQ-002 SHALL have ports: clk  in  1  system clock (50 MHz); one clock only, all logic on rising edge.
REQ-003 SHALL have ports: RST  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: DATA  in  16  MCU 8080 data bus; CS, RS, WR, RD  in  1 each  MCU strobes (asynchronous, active-low CS/WR/RD; RS 0=command, 1=data).
REQ-005 SHALL have ports: pwm_duty  out  4  backlight duty 0-15.
REQ-006 SHALL have ports: pix_valid  out  1; pix_ready  in  1; pix_row  out  9; pix_col  out  10; pix_data  out  16  RGB565 pixel write toward SDRAM controller.
REQ-007 SHALL have ports: overflow  out  1  sticky FIFO overflow flag.
REQ-008 SHALL have ports (MCU_READBACK_EN only): dout  out  16; dout_oe  out  1.

Function
REQ-009 SHALL synchronise CS, RS, WR, RD through 2 flops each; DATA sampled unsynchronised at detected edge.
REQ-010 SHALL detect a write strobe as synced WR 0->1 while synced CS=0; capture DATA and synced RS that same cycle (MCU holds DATA ≥4 clk after WR rise).
REQ-011 SHALL, on command write (RS=0), load index register with DATA[7:0]; index 0x0F additionally loads cursor=(row_s,col_s) and clears overflow.
REQ-012 SHALL, on data write (RS=1), act by index: 0x01 pwm_duty<=DATA[3:0]; 0x02 row_s; 0x03 col_s; 0x06 row_e; 0x07 col_e; 0x0F push pixel; other index ignored.
REQ-013 SHALL clamp row values >V_RES-1 to V_RES-1 and col values >H_RES-1 to H_RES-1 on load.
REQ-014 SHALL, per pushed pixel, advance cursor: col==col_e -> col=col_s, row++; additionally row==row_e -> row=row_s (window wrap); else col++.
REQ-015 SHALL treat col_s>col_e or row_s>row_e as single-column/row window (cursor stays at start on that axis).
REQ-016 SHALL buffer {row,col,data} in FIFO; pix_valid=~empty; pop on pix_valid&&pix_ready; first-word latency 1 clk after push.
REQ-017 SHALL, on push while full with no same-cycle pop, drop pixel, still advance cursor, set overflow; simultaneous push+pop when full SHALL succeed.
REQ-018 SHALL ignore all strobes while synced CS=1; CS rising mid-stream leaves registers and cursor intact.

Reset
REQ-019 SHALL on RST=0 asynchronously clear: sync flops to idle (1), index 0x00, pwm_duty 0, row_s/col_s 0, row_e V_RES-1, col_e H_RES-1, cursor 0, FIFO empty, pix_valid 0, overflow 0, dout 0, dout_oe 0.
REQ-020 SHALL discard FIFO contents on reset mid-stream; pixels outstanding are lost.

Configuration
REQ-021 SHALL compile readback with macro MCU_READBACK_EN: defined -> while synced CS=0,RD=0,RS=1 dout_oe=1, dout= register selected by index (0x01 zero-extended pwm_duty, 0x02/03/06/07 window regs, 0x10 status {15'b0,overflow}, else 0); undefined -> dout/dout_oe absent, RD ignored.

Structure
REQ-022 SHALL place command codes (0x01,0x02,0x03,0x06,0x07,0x0F,0x10), row/col widths and pixel-word struct in package tft_cmd_pkg.
REQ-023 SHALL implement the FIFO as sub-module pix_fifo (parameterised depth/width, full/empty, no overflow write).

Verification
REQ-024 SHALL cover: cmd 0x01, data 0x0002 -> pwm_duty=2 within 5 clk of WR rise.
REQ-025 SHALL cover: row_e=479, col_e=799, row_s=470, col_s=790, cmd 0x0F, 12 pixels 0x001F.. with pix_ready=1 -> (470,790..799) then (471,790),(471,791), data incrementing.
REQ-026 SHALL cover: window 2x2 at (0,0), 5 pixels -> 5th pixel at (0,0) (wrap).
REQ-027 SHALL cover: pix_ready=0, FIFO_DEPTH+2 pixels -> 4 held, overflow=1; cmd 0x0F -> overflow=0.
REQ-028 SHALL cover: RST low during streaming -> pix_valid=0 same cycle, window regs at reset values.
REQ-029 SHALL cover (MCU_READBACK_EN): cmd 0x07, data 900, RD low -> dout=799, dout_oe=1.

Source files
------------

// File: rtl/tft_cmd_pkg.sv
// tft_cmd_pkg: shared definitions for the MCU 8080 bus decoder.
//   - command/index codes understood by mcu_bus_decoder
//   - row/column/data widths and the pixel word pushed into the pixel FIFO
//   - clamp helpers used when loading window registers
package tft_cmd_pkg;

    localparam int unsigned RowW  = 9;
    localparam int unsigned ColW  = 10;
    localparam int unsigned DataW = 16;

    localparam logic [7:0] CmdNop    = 8'h00;
    localparam logic [7:0] CmdPwm    = 8'h01;
    localparam logic [7:0] CmdRowS   = 8'h02;
    localparam logic [7:0] CmdColS   = 8'h03;
    localparam logic [7:0] CmdRowE   = 8'h06;
    localparam logic [7:0] CmdColE   = 8'h07;
    localparam logic [7:0] CmdPixel  = 8'h0F;
    localparam logic [7:0] CmdStatus = 8'h10;

    typedef struct packed {
        logic [RowW-1:0]  row;
        logic [ColW-1:0]  col;
        logic [DataW-1:0] data;
    } pix_word_t;

    localparam int unsigned PixW = $bits(pix_word_t);

    // Saturate a bus value to lim-1 (lim is the panel dimension).
    function automatic logic [RowW-1:0] clamp_row(input logic [15:0] v, input int unsigned lim);
        if (32'(v) >= lim) return RowW'(lim - 1);
        return v[RowW-1:0];
    endfunction

    function automatic logic [ColW-1:0] clamp_col(input logic [15:0] v, input int unsigned lim);
        if (32'(v) >= lim) return ColW'(lim - 1);
        return v[ColW-1:0];
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous first-word-fall-through FIFO for pixel words.
//   clk_i, rst_ni   clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i write request and data; ignored when full unless popped same cycle
//   pop_i, rdata_o  read request and head-of-queue data (valid while !empty_o)
//   full_o, empty_o occupancy flags
module pix_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AddrW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are meaningless while count_q says empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mcu_bus_decoder.sv
// mcu_bus_decoder: MCU 8080-style bus front end for a TFT panel.
// Decodes command/data writes into backlight duty, a drawing window and a
// pixel stream (row, col, RGB565) buffered toward the SDRAM controller.
//   clk              system clock, all logic on rising edge
//   RST              asynchronous active-low reset
//   DATA, CS, RS,    asynchronous MCU bus; CS/WR/RD active-low, RS 0=command 1=data
//   WR, RD
//   pwm_duty         backlight duty 0-15
//   pix_valid/ready  pixel handshake; pix_row, pix_col, pix_data carry the pixel
//   overflow         sticky: a pixel was dropped because the FIFO was full
//   dout, dout_oe    register readback (only when MCU_READBACK_EN is defined)
// Compile-time option: MCU_READBACK_EN adds the readback path and its ports.
module mcu_bus_decoder
    import tft_cmd_pkg::*;
#(
    parameter int unsigned H_RES      = 800,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [15:0]      DATA,
    input  logic             CS,
    input  logic             RS,
    input  logic             WR,
    input  logic             RD,
    output logic [3:0]       pwm_duty,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [RowW-1:0]  pix_row,
    output logic [ColW-1:0]  pix_col,
    output logic [DataW-1:0] pix_data,
    output logic             overflow
`ifdef MCU_READBACK_EN
    ,
    output logic [15:0]      dout,
    output logic             dout_oe
`endif
);

    // Strobe synchronisers; idle level is 1 for all of them.
    logic [1:0] cs_sync_q, rs_sync_q, wr_sync_q, rd_sync_q;
    logic       wr_prev_q;
    logic       cs_s, rs_s, wr_s, rd_s;

    logic [7:0]      index_q;
    logic [3:0]      pwm_duty_q;
    logic [RowW-1:0] row_s_q, row_e_q, cur_row_q, next_row;
    logic [ColW-1:0] col_s_q, col_e_q, cur_col_q, next_col;
    logic            overflow_q;

    logic      wr_strobe, cmd_wr, dat_wr, pix_push;
    logic      fifo_full, fifo_empty, fifo_pop;
    pix_word_t pix_in, pix_out;

    assign cs_s = cs_sync_q[1];
    assign rs_s = rs_sync_q[1];
    assign wr_s = wr_sync_q[1];
    assign rd_s = rd_sync_q[1];

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cs_sync_q <= 2'b11;
            rs_sync_q <= 2'b11;
            wr_sync_q <= 2'b11;
            rd_sync_q <= 2'b11;
            wr_prev_q <= 1'b1;
        end else begin
            cs_sync_q <= {cs_sync_q[0], CS};
            rs_sync_q <= {rs_sync_q[0], RS};
            wr_sync_q <= {wr_sync_q[0], WR};
            rd_sync_q <= {rd_sync_q[0], RD};
            wr_prev_q <= wr_s;
        end
    end

    // The write completes on the WR rising edge; DATA is still held by the MCU here.
    assign wr_strobe = !wr_prev_q && wr_s && !cs_s;
    assign cmd_wr    = wr_strobe && !rs_s;
    assign dat_wr    = wr_strobe && rs_s;
    assign pix_push  = dat_wr && (index_q == CmdPixel);

    // Cursor step. Using >= against the end register also covers the
    // inverted-window case (start > end): the cursor is loaded at start, which
    // already counts as "at end", so that axis never leaves start.
    always_comb begin
        next_col = cur_col_q + 1'b1;
        next_row = cur_row_q;
        if (cur_col_q >= col_e_q) begin
            next_col = col_s_q;
            next_row = (cur_row_q >= row_e_q) ? row_s_q : cur_row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            index_q    <= CmdNop;
            pwm_duty_q <= '0;
            row_s_q    <= '0;
            col_s_q    <= '0;
            row_e_q    <= RowW'(V_RES - 1);
            col_e_q    <= ColW'(H_RES - 1);
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            overflow_q <= 1'b0;
        end else if (cmd_wr) begin
            index_q <= DATA[7:0];
            if (DATA[7:0] == CmdPixel) begin
                cur_row_q  <= row_s_q;
                cur_col_q  <= col_s_q;
                overflow_q <= 1'b0;
            end
        end else if (dat_wr) begin
            case (index_q)
                CmdPwm:  pwm_duty_q <= DATA[3:0];
                CmdRowS: row_s_q    <= clamp_row(DATA, V_RES);
                CmdColS: col_s_q    <= clamp_col(DATA, H_RES);
                CmdRowE: row_e_q    <= clamp_row(DATA, V_RES);
                CmdColE: col_e_q    <= clamp_col(DATA, H_RES);
                CmdPixel: begin
                    // Dropped pixels still advance so later pixels land where the MCU expects.
                    cur_row_q <= next_row;
                    cur_col_q <= next_col;
                    if (fifo_full && !fifo_pop) overflow_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pix_in   = '{row: cur_row_q, col: cur_col_q, data: DATA};
    assign fifo_pop = pix_valid && pix_ready;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PixW)
    ) u_pix_fifo (
        .clk_i   (clk),
        .rst_ni  (RST),
        .push_i  (pix_push),
        .wdata_i (pix_in),
        .pop_i   (fifo_pop),
        .rdata_o (pix_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign pix_row   = pix_out.row;
    assign pix_col   = pix_out.col;
    assign pix_data  = pix_out.data;
    assign pwm_duty  = pwm_duty_q;
    assign overflow  = overflow_q;

`ifdef MCU_READBACK_EN
    logic [15:0] rb_sel;
    logic [15:0] dout_q;
    logic        dout_oe_q;

    always_comb begin
        rb_sel = '0;
        case (index_q)
            CmdPwm:    rb_sel = {12'b0, pwm_duty_q};
            CmdRowS:   rb_sel = {{(16-RowW){1'b0}}, row_s_q};
            CmdColS:   rb_sel = {{(16-ColW){1'b0}}, col_s_q};
            CmdRowE:   rb_sel = {{(16-RowW){1'b0}}, row_e_q};
            CmdColE:   rb_sel = {{(16-ColW){1'b0}}, col_e_q};
            CmdStatus: rb_sel = {15'b0, overflow_q};
            default:   rb_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            dout_q    <= '0;
            dout_oe_q <= 1'b0;
        end else begin
            dout_oe_q <= !cs_s && !rd_s && rs_s;
            dout_q    <= rb_sel;
        end
    end

    assign dout    = dout_q;
    assign dout_oe = dout_oe_q;
`else
    // RD has no function without readback; keep the synchroniser output as a sink.
    logic unused_rd;
    assign unused_rd = rd_s;
`endif

endmodule

// File: tb/tb_mcu_bus_decoder.sv
// tb_mcu_bus_decoder: directed stimulus for mcu_bus_decoder with a pixel scoreboard.
// Expected pixels are queued as writes are issued; a monitor pops on each accepted pixel.
module tb_mcu_bus_decoder;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DATA = '0;
    logic        CS = 1'b1, RS = 1'b1, WR = 1'b1, RD = 1'b1;
    logic [3:0]  pwm_duty;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [8:0]  pix_row;
    logic [9:0]  pix_col;
    logic [15:0] pix_data;
    logic        overflow;
`ifdef MCU_READBACK_EN
    logic [15:0] dout;
    logic        dout_oe;
`endif

    mcu_bus_decoder #(
        .H_RES      (800),
        .V_RES      (480),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .DATA      (DATA),
        .CS        (CS),
        .RS        (RS),
        .WR        (WR),
        .RD        (RD),
        .pwm_duty  (pwm_duty),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_data  (pix_data),
        .overflow  (overflow)
`ifdef MCU_READBACK_EN
        ,
        .dout      (dout),
        .dout_oe   (dout_oe)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Monitor: sample mid-low-phase, after stimulus has settled, before the popping edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (RST && pix_valid && pix_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected got row=%0d col=%0d data=%h required none",
                         pix_row, pix_col, pix_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(pix_row) != e.row || int'(pix_col) != e.col || int'(pix_data) != e.data)
                begin
                    errors++;
                    $display("FAIL pixel got row=%0d col=%0d data=%h required row=%0d col=%0d data=%h",
                             pix_row, pix_col, pix_data, e.row, e.col, e.data);
                end
            end
        end
    end

    // One MCU bus cycle: strobe low 4 clk, DATA held 5 clk after the rising edge.
    task automatic wr(input logic cs_v, input logic rs_v, input logic [15:0] d);
        @(negedge clk);
        CS   = cs_v;
        RS   = rs_v;
        DATA = d;
        WR   = 1'b0;
        repeat (4) @(negedge clk);
        WR = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic cmd(input logic [15:0] c, input logic [15:0] d);
        wr(1'b0, 1'b0, c);
        wr(1'b0, 1'b1, d);
    endtask

    task automatic px(input int r, input int c, input logic [15:0] d);
        exp_t e;
        e.row = r;
        e.col = c;
        e.data = int'(d);
        exp_q.push_back(e);
        wr(1'b0, 1'b1, d);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    int r26[5] = '{0, 0, 1, 1, 0};
    int c26[5] = '{0, 1, 0, 1, 0};

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_pix_valid", pix_valid, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_pwm", pwm_duty, 0);
        RST = 1'b1;
        repeat (3) @(negedge clk);

        // Backlight duty
        cmd(16'h0001, 16'h0002);
        chk("pwm_duty", pwm_duty, 2);

        // Strobes with CS high are ignored
        wr(1'b1, 1'b1, 16'h000F);
        repeat (3) @(negedge clk);
        chk("pwm_cs_high", pwm_duty, 2);

        // Window at the panel corner, cursor wraps to next row
        pix_ready = 1'b1;
        cmd(16'h0006, 16'd479);
        cmd(16'h0007, 16'd799);
        cmd(16'h0002, 16'd470);
        cmd(16'h0003, 16'd790);
        wr(1'b0, 1'b0, 16'h000F);
        for (int i = 0; i < 12; i++) px(470 + i / 10, 790 + i % 10, 16'h001F + 16'(i));
        drain("drain_corner");

        // 2x2 window, fifth pixel wraps to start
        cmd(16'h0002, 16'd0);
        cmd(16'h0003, 16'd0);
        cmd(16'h0006, 16'd1);
        cmd(16'h0007, 16'd1);
        wr(1'b0, 1'b0, 16'h000F);
        for (int i = 0; i < 5; i++) px(r26[i], c26[i], 16'hA000 + 16'(i));
        drain("drain_wrap");

        // Overflow: FIFO holds 4, two more are dropped but still advance the cursor
        pix_ready = 1'b0;
        wr(1'b0, 1'b0, 16'h000F);
        for (int i = 0; i < 4; i++) px(r26[i], c26[i], 16'hB000 + 16'(i));
        chk("full_pix_valid", pix_valid, 1);
        chk("overflow_at_full", overflow, 0);
        wr(1'b0, 1'b1, 16'hB004);
        wr(1'b0, 1'b1, 16'hB005);
        chk("overflow_set", overflow, 1);
        pix_ready = 1'b1;
        drain("drain_overflow");
        repeat (3) @(negedge clk);
        chk("fifo_empty_after_drain", pix_valid, 0);
        chk("overflow_sticky", overflow, 1);
        px(1, 0, 16'hB006);
        drain("drain_after_drop");
        wr(1'b0, 1'b0, 16'h000F);
        chk("overflow_cleared", overflow, 0);

        // Reset mid-stream
        pix_ready = 1'b0;
        cmd(16'h0002, 16'd5);
        cmd(16'h0003, 16'd5);
        wr(1'b0, 1'b0, 16'h000F);
        wr(1'b0, 1'b1, 16'hC000);
        wr(1'b0, 1'b1, 16'hC001);
        chk("pre_reset_valid", pix_valid, 1);
        @(negedge clk);
        #3 RST = 1'b0;
        #1;
        chk("reset_mid_valid", pix_valid, 0);
        chk("reset_mid_pwm", pwm_duty, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        RST = 1'b1;
        repeat (3) @(negedge clk);
        pix_ready = 1'b1;
        cmd(16'h0003, 16'd798);
        wr(1'b0, 1'b0, 16'h000F);
        px(0, 798, 16'hD000);
        px(0, 799, 16'hD001);
        px(1, 798, 16'hD002);
        drain("drain_after_reset");

`ifdef MCU_READBACK_EN
        // Readback of a clamped column end
        cmd(16'h0007, 16'd900);
        @(negedge clk);
        RS = 1'b1;
        RD = 1'b0;
        repeat (4) @(negedge clk);
        chk("readback_dout", dout, 799);
        chk("readback_oe", dout_oe, 1);
        RD = 1'b1;
        repeat (4) @(negedge clk);
        chk("readback_oe_off", dout_oe, 0);
`endif

        CS = 1'b1;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
